// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchroniser, mid-bit sampling and a 1-entry valid/ready holding register.
// Define UART_RX_WORD_EN to pair consecutive bytes into one 16-bit word (first byte in [7:0]).
module uart_rx #(
    parameter int CLOCK_SPEED    = 100_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int CLOCKS_PER_BIT = (CLOCK_SPEED / BAUD_RATE) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [13:0] HALF_LAST = 14'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [13:0] BIT_LAST  = 14'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t      state_q;
    logic        sync1_q, rxs_q;
    logic [13:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        byte_done_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        rx_valid_q;
    logic [15:0] rx_data_q;
    logic        deliver_d;
    logic [15:0] result_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    // A start bit that has vanished by mid-bit is treated as a glitch.
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rxs_q;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rxs_q) begin
                            state_q     <= S_IDLE;
                            byte_done_q <= 1'b1;
                        end else begin
                            state_q     <= S_BRK;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                S_BRK: begin
                    // Hold here until the line goes idle so a stuck-low line cannot retrigger.
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_WORD_EN
    logic       phase_q;
    logic [7:0] lo_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= 1'b0;
            lo_q    <= '0;
        end else if (frame_err_q) begin
            phase_q <= 1'b0;
        end else if (byte_done_q) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
                lo_q <= shift_q;
            end
        end
    end

    always_comb begin
        deliver_d = byte_done_q && phase_q;
        result_d  = {shift_q, lo_q};
    end
`else
    always_comb begin
        deliver_d = byte_done_q;
        result_d  = {8'h00, shift_q};
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (deliver_d) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q  <= result_d;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
